// File: rtl/pipe_hazard_sched.sv
// Hazard and stall scheduler for the 5-stage core: stage enables, flushes and bubbles,
// driven by ID-stage load-use/branch-operand hazards and data-memory wait states.
module pipe_hazard_sched #(
    parameter int unsigned TO_CYCLES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       id_npcop,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_br_eq,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             dmem_req,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WCNT_W = $clog2(TO_CYCLES + 1);

    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [WCNT_W-1:0] wcnt, wcnt_nx;
    logic              freeze;
    logic              timeout_evt;

    logic ex_hit, mem_hit;
    logic is_br_op;
    logic load_use, br_dep, id_stall, redirect;

    // Operand match against a producer; r0 is hardwired zero so never a hazard.
    assign ex_hit  = (ex_rd != 5'd0) &
                     ((id_use_rs & (ex_rd == id_rs)) | (id_use_rt & (ex_rd == id_rt)));
    assign mem_hit = (mem_rd != 5'd0) &
                     ((id_use_rs & (mem_rd == id_rs)) | (id_use_rt & (mem_rd == id_rt)));

    assign is_br_op = (id_npcop == NPC_BRANCH) | (id_npcop == NPC_JR);
    assign load_use = ex_memread & ex_hit;
    assign br_dep   = is_br_op & ((ex_regwrite & ex_hit) | (mem_memread & mem_hit));
    assign id_stall = load_use | br_dep;
    assign redirect = ~id_stall & ((id_npcop == NPC_JUMP) | (id_npcop == NPC_JR) |
                                   ((id_npcop == NPC_BRANCH) & id_br_eq));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // Data-memory wait tracking, then stage control by priority.
    always_comb begin
        state_nx     = state;
        wcnt_nx      = wcnt;
        freeze       = 1'b0;
        timeout_evt  = 1'b0;
        dmem_req     = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;

        case (state)
            ST_RUN: begin
                dmem_req = mem_access;
                if (mem_access && !dmem_ready) begin
                    freeze   = 1'b1;
                    wcnt_nx  = WCNT_W'(1);
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready || !mem_access) begin
                    wcnt_nx  = '0;
                    state_nx = ST_RUN;
                end else if (wcnt == WCNT_W'(TO_CYCLES)) begin
                    timeout_evt = 1'b1;
                    wcnt_nx     = '0;
                    state_nx    = ST_RUN;
                end else begin
                    freeze  = 1'b1;
                    wcnt_nx = wcnt + WCNT_W'(1);
                end
            end
            default: begin
                wcnt_nx  = '0;
                state_nx = ST_RUN;
            end
        endcase

        if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else begin
            if (id_stall) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (redirect) begin
                ifid_flush = 1'b1;
            end
            // A timed-out load must not write back.
            if (timeout_evt) begin
                memwb_bubble = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
            dmem_req     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if ((freeze || id_stall) && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (timeout_evt) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Scoreboard bench for pipe_hazard_sched: directed hazard/wait scenarios then random traffic,
// expected responses from a rule-level reference model.
module tb_pipe_hazard_sched;

    localparam int unsigned TO    = 16;
    localparam int unsigned CW    = 5;
    localparam int          MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    id_npcop = '0;
    logic [4:0]    id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
    logic          id_use_rs = 0, id_use_rt = 0, id_br_eq = 0;
    logic          ex_regwrite = 0, ex_memread = 0, mem_memread = 0;
    logic          mem_access = 0, dmem_ready = 0;
    logic          pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
    logic          memwb_bubble, dmem_req, mem_timeout;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_sched #(.TO_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_npcop(id_npcop), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_br_eq(id_br_eq),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_rd(mem_rd), .mem_access(mem_access),
        .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .dmem_req(dmem_req), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rstn;
        bit [1:0] npc;
        bit [4:0] rs, rt, ex_rd, mem_rd;
        bit       use_rs, use_rt, br_eq, ex_rw, ex_mr, mem_mr, acc, rdy;
    } stim_t;

    typedef struct {
        bit [7:0] ctl;   // {pc,ifid,idex,exmem enables, ifid_flush, idex_flush, bubble, req}
        int       cnt;
        bit       to;
        int       cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    // Reference model state: cycles this access has already spent frozen, stall total, sticky flag.
    int m_frozen = 0;
    int m_cnt    = 0;
    bit m_to     = 0;

    function automatic bit hits(input stim_t s, input bit [4:0] rd);
        return (rd != 0) && ((s.use_rs && rd == s.rs) || (s.use_rt && rd == s.rt));
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rstn = 1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit lu, bd, stall, redir, frz, req, tmo;
        @(posedge clk);
        #1;
        rst_n = s.rstn; id_npcop = s.npc; id_rs = s.rs; id_rt = s.rt;
        id_use_rs = s.use_rs; id_use_rt = s.use_rt; id_br_eq = s.br_eq;
        ex_regwrite = s.ex_rw; ex_memread = s.ex_mr; ex_rd = s.ex_rd;
        mem_memread = s.mem_mr; mem_rd = s.mem_rd; mem_access = s.acc; dmem_ready = s.rdy;
        cyc++;
        e.cyc = cyc;
        if (!s.rstn) begin
            m_frozen = 0; m_cnt = 0; m_to = 0;
            e.ctl = 8'b0000_1110; e.cnt = 0; e.to = 0;
            q.push_back(e);
            return;
        end
        lu    = s.ex_mr && hits(s, s.ex_rd);
        bd    = (s.npc == 2'd1 || s.npc == 2'd3) &&
                ((s.ex_rw && hits(s, s.ex_rd)) || (s.mem_mr && hits(s, s.mem_rd)));
        stall = lu || bd;
        redir = !stall && (s.npc == 2'd2 || s.npc == 2'd3 || (s.npc == 2'd1 && s.br_eq));
        frz = 0; tmo = 0;
        if (m_frozen == 0) begin
            req = s.acc;
            frz = s.acc && !s.rdy;
            m_frozen = frz ? 1 : 0;
        end else begin
            req = 1;
            if (s.rdy || !s.acc) m_frozen = 0;
            else if (m_frozen == TO) begin tmo = 1; m_frozen = 0; end
            else begin frz = 1; m_frozen++; end
        end
        if (frz)        e.ctl = {4'b0000, 1'b0, 1'b0, 1'b1, req};
        else if (stall) e.ctl = {4'b0011, 1'b0, 1'b1, tmo,  req};
        else if (redir) e.ctl = {4'b1111, 1'b1, 1'b0, tmo,  req};
        else            e.ctl = {4'b1111, 1'b0, 1'b0, tmo,  req};
        e.cnt = m_cnt;
        e.to  = m_to;
        q.push_back(e);
        if ((frz || stall) && m_cnt < MAXC) m_cnt++;
        if (tmo) m_to = 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [7:0] act;
        if (q.size() != 0) begin
            e   = q.pop_front();
            act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, dmem_req};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("FAIL ctl cyc=%0d got=%b exp=%b", e.cyc, act, e.ctl);
            end
            checks++;
            if (stall_cnt !== CW'(e.cnt)) begin
                errors++;
                $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", e.cyc, stall_cnt, e.cnt);
            end
            checks++;
            if (mem_timeout !== e.to) begin
                errors++;
                $display("FAIL mem_timeout cyc=%0d got=%b exp=%b", e.cyc, mem_timeout, e.to);
            end
        end
    end

    initial begin
        stim_t s;
        s = idle(); s.rstn = 0;
        step(s); step(s);
        // load-use on rs
        s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 5'd8; s.rs = 5'd8; s.use_rs = 1;
        step(s);
        step(idle()); step(idle());
        // beq after ALU op
        s = idle(); s.npc = 2'd1; s.rs = 5'd5; s.use_rs = 1; s.use_rt = 1; s.ex_rw = 1; s.ex_rd = 5'd5;
        step(s);
        s.ex_rw = 0; s.ex_rd = 0; s.br_eq = 1;
        step(s);
        // beq after lw: EX hit then MEM hit
        s = idle(); s.npc = 2'd1; s.rt = 5'd5; s.use_rt = 1; s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 5'd5;
        step(s);
        s.ex_mr = 0; s.ex_rw = 0; s.ex_rd = 0; s.mem_mr = 1; s.mem_rd = 5'd5;
        step(s);
        s.mem_mr = 0; s.mem_rd = 0; s.br_eq = 1;
        step(s);
        // r0 never hazards; jump and jr redirect
        s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.use_rs = 1; s.npc = 2'd3;
        step(s);
        s = idle(); s.npc = 2'd2; step(s);
        // short dmem wait
        s = idle(); s.acc = 1;
        for (int i = 0; i < 3; i++) step(s);
        s.rdy = 1; step(s);
        step(idle());
        // timeout
        s = idle(); s.acc = 1;
        for (int i = 0; i < TO + 1; i++) step(s);
        step(idle()); step(idle());
        // reset mid-wait
        s = idle(); s.acc = 1;
        for (int i = 0; i < 5; i++) step(s);
        s.rstn = 0; step(s); step(s);
        step(idle()); step(idle());
        // random traffic with occasional stuck memory and resets
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.npc    = 2'($urandom_range(0, 3));
            s.rs     = 5'($urandom_range(0, 3));
            s.rt     = 5'($urandom_range(0, 3));
            s.ex_rd  = 5'($urandom_range(0, 3));
            s.mem_rd = 5'($urandom_range(0, 3));
            s.use_rs = 1'($urandom_range(0, 1));
            s.use_rt = 1'($urandom_range(0, 1));
            s.br_eq  = 1'($urandom_range(0, 1));
            s.ex_rw  = 1'($urandom_range(0, 1));
            s.ex_mr  = 1'($urandom_range(0, 1));
            s.mem_mr = 1'($urandom_range(0, 1));
            s.acc    = ($urandom_range(0, 3) != 0);
            s.rdy    = (i % 200 > 170) ? 1'b0 : ($urandom_range(0, 9) < 3);
            s.rstn   = ($urandom_range(0, 499) != 0);
            step(s);
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
